dbus_bridge: RTL and testbench

Data-side bus bridge between the MEM stage and the external data memory bus. It takes MEM's single-cycle memory request (chip enable, write enable, address, byte selects, store data) and turns it into a registered, ack-terminated, multi-cycle bus transaction. It stalls the pipeline until the transaction completes and returns load data to MEM for byte/halfword extraction and LWL/LWR merging. It also holds completed results while the pipeline is frozen by other stall sources, so that no request is reissued.

---
 rtl/dbus_bridge.sv | 164 ++++++++++++++++
 tb/tb_dbus_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_bridge.sv
// Data-side bus bridge: turns MEM's one-cycle request into an ack-terminated bus transaction.
// Optional watchdog abort is enabled by defining DBUS_TIMEOUT_EN.
module dbus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_req_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [31:0] cpu_data_s;
    logic        stall_req_s;
    logic        tmo_s;
    logic        err_d;

`ifdef DBUS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign tmo_s     = (state_q == S_BUSY) && !bus_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign bus_err_o = err_q;

    // Watchdog counter and the registered abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    localparam int unused_cfg = TIMEOUT_CYCLES + CNT_W;
    assign tmo_s     = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // State and latched bus request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            sel_q    <= 4'h0;
            wdata_q  <= 32'h0;
            rd_buf_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Next-state and combinational handshake outputs.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        rd_buf_d    = rd_buf_q;
        stall_req_s = 1'b0;
        cpu_data_s  = 32'h0;
        err_d       = 1'b0;
`ifdef DBUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // An external stall does not block issue; HOLD prevents a reissue later.
                stall_req_s = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    we_d    = cpu_we_i;
                    addr_d  = {cpu_addr_i[31:2], 2'b00};
                    sel_d   = cpu_sel_i;
                    wdata_d = cpu_data_i;
`ifdef DBUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (bus_ack_i || tmo_s) begin
                    // Stores and aborts return zero to MEM.
                    cpu_data_s = (we_q || tmo_s) ? 32'h0 : bus_rdata_i;
                    rd_buf_d   = cpu_data_s;
                    req_d      = 1'b0;
                    err_d      = tmo_s;
                    state_d    = stall_i ? S_HOLD : S_IDLE;
                end else begin
                    stall_req_s = 1'b1;
`ifdef DBUS_TIMEOUT_EN
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_HOLD: begin
                cpu_data_s = rd_buf_q;
                if (flush_i || !stall_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign cpu_data_o  = cpu_data_s;
    assign stall_req_o = stall_req_s;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed plus randomized bench for dbus_bridge; the bus slave and expectations live here.
module tb_dbus_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ce_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = 32'h0;
    logic [3:0]  cpu_sel_i = 4'h0;
    logic [31:0] cpu_data_i = 32'h0;
    logic [31:0] cpu_data_o;
    logic        stall_req_o;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;
    int txn = 0;
    int exp_txn = 0;
    logic req_prev = 1'b0;

    dbus_bridge #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stall_req_o(stall_req_o), .stall_i(stall_i), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    // Count bus transactions as rising edges of the request line.
    always @(posedge clk) begin
        if (bus_req_o && !req_prev) txn <= txn + 1;
        req_prev <= bus_req_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete access: issue cycle, 'waits' wait states, then ack with stall_i = ext.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input logic ext);
        int stalls;
        stalls = 0;
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wd;
        bus_ack_i = 1'b0;
        @(negedge clk);
        chk("issue_stall", {31'h0, stall_req_o}, 32'h1);
        if (stall_req_o) stalls++;
        next_cycle();
        cpu_ce_i = 1'b0;
        cpu_addr_i = $urandom; cpu_data_i = $urandom;
        exp_txn++;
        for (int k = 0; k <= waits; k++) begin
            bus_ack_i   = (k == waits);
            bus_rdata_i = (k == waits) ? rd : 32'($urandom);
            stall_i     = (k == waits) ? ext : 1'b0;
            @(negedge clk);
            if (stall_req_o) stalls++;
            chk("busy_req", {31'h0, bus_req_o}, 32'h1);
            chk("busy_addr", bus_addr_o, {addr[31:2], 2'b00});
            chk("busy_sel", {28'h0, bus_sel_o}, {28'h0, sel});
            chk("busy_we", {31'h0, bus_we_o}, {31'h0, we});
            chk("busy_wdata", bus_wdata_o, wd);
            chk("busy_data", cpu_data_o, (k == waits && !we) ? rd : 32'h0);
            next_cycle();
        end
        bus_ack_i = 1'b0;
        chk("stall_len", 32'(stalls), 32'(1 + waits));
    endtask

    initial begin
        // Reset from power-up.
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_req", {31'h0, bus_req_o}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_data", cpu_data_o, 32'h0);
        chk("rst_stall", {31'h0, stall_req_o}, 32'h0);
        chk("rst_err", {31'h0, bus_err_o}, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Reset while BUSY.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'hABCD_0003; cpu_sel_i = 4'hF;
        cpu_data_i = 32'h5555_AAAA;
        next_cycle();
        cpu_ce_i = 1'b0;
        exp_txn++;
        @(negedge clk);
        chk("pre_rst_req", {31'h0, bus_req_o}, 32'h1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("midrst_req", {31'h0, bus_req_o}, 32'h0);
        chk("midrst_we", {31'h0, bus_we_o}, 32'h0);
        chk("midrst_addr", bus_addr_o, 32'h0);
        chk("midrst_sel", {28'h0, bus_sel_o}, 32'h0);
        chk("midrst_wdata", bus_wdata_o, 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("postrst_req", {31'h0, bus_req_o}, 32'h0);
        chk("postrst_stall", {31'h0, stall_req_o}, 32'h0);
        next_cycle();

        // Load with two wait states.
        access(1'b0, 32'h0000_1006, 4'b0011, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
        @(negedge clk);
        chk("load_idle_req", {31'h0, bus_req_o}, 32'h0);
        chk("load_idle_data", cpu_data_o, 32'h0);
        next_cycle();

        // Store, zero wait.
        access(1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'hFFFF_0000, 0, 1'b0);
        @(negedge clk);
        chk("store_idle_req", {31'h0, bus_req_o}, 32'h0);
        next_cycle();
        chk("store_txn", 32'(txn), 32'(exp_txn));

        // Completion during an external stall: HOLD keeps the data, no reissue.
        access(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stall_i = (i < 2);
            @(negedge clk);
            chk("hold_data", cpu_data_o, 32'hCAFE_F00D);
            chk("hold_req", {31'h0, bus_req_o}, 32'h0);
            chk("hold_stall", {31'h0, stall_req_o}, 32'h0);
            next_cycle();
        end
        @(negedge clk);
        chk("hold_exit_data", cpu_data_o, 32'h0);
        next_cycle();
        chk("hold_txn", 32'(txn), 32'(exp_txn));

        // Flush in BUSY, then a late ack.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
        next_cycle();
        cpu_ce_i = 1'b0; exp_txn++;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'h0, stall_req_o}, 32'h0);
        next_cycle();
        flush_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        @(negedge clk);
        chk("flush_req", {31'h0, bus_req_o}, 32'h0);
        chk("late_ack_data", cpu_data_o, 32'h0);
        chk("late_ack_stall", {31'h0, stall_req_o}, 32'h0);
        next_cycle();
        bus_ack_i = 1'b0;

        // Flush and ack together: flush wins.
        cpu_ce_i = 1'b1;
        next_cycle();
        cpu_ce_i = 1'b0; exp_txn++;
        flush_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_4444;
        @(negedge clk);
        chk("flushack_data", cpu_data_o, 32'h0);
        chk("flushack_stall", {31'h0, stall_req_o}, 32'h0);
        next_cycle();
        flush_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        chk("flushack_req", {31'h0, bus_req_o}, 32'h0);
        next_cycle();

        // Flush in IDLE suppresses the request.
        cpu_ce_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", {31'h0, stall_req_o}, 32'h0);
        next_cycle();
        cpu_ce_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_req", {31'h0, bus_req_o}, 32'h0);
        next_cycle();

        // Flush while in HOLD forces IDLE.
        access(1'b0, 32'h0000_4000, 4'b1100, 32'h0, 32'h7777_8888, 0, 1'b1);
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        @(negedge clk);
        chk("holdflush_data", cpu_data_o, 32'h0);
        stall_i = 1'b0;
        next_cycle();

        // Randomized back-to-back accesses.
        for (int n = 0; n < 24; n++) begin
            access(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3), 1'b0);
        end
        stall_i = 1'b0;
        next_cycle();
        chk("random_txn", 32'(txn), 32'(exp_txn));

`ifdef DBUS_TIMEOUT_EN
        begin
            int rel_k;
            int errs;
            rel_k = -1;
            errs = 0;
            cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h500;
            next_cycle();
            cpu_ce_i = 1'b0;
            for (int k = 0; k < 12; k++) begin
                bus_rdata_i = $urandom;
                @(negedge clk);
                if (bus_err_o) errs++;
                if (!stall_req_o && rel_k < 0) begin
                    rel_k = k;
                    chk("tmo_data", cpu_data_o, 32'h0);
                end
                next_cycle();
            end
            chk("tmo_release", 32'(rel_k), 32'(TMO));
            chk("tmo_err_pulses", 32'(errs), 32'h1);
            @(negedge clk);
            chk("tmo_idle_req", {31'h0, bus_req_o}, 32'h0);
            chk("tmo_idle_stall", {31'h0, stall_req_o}, 32'h0);
            next_cycle();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
